// File: rtl/fp32_mul.sv
// FP32 multiplier, 3-stage pipeline with global stall.
// Subnormals flush to zero, truncating rounding, overflow saturates to infinity.
module fp32_mul #(
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] y
);

    if (PIPE_STAGES != 3) begin : g_bad_stages
        $error("fp32_mul: only PIPE_STAGES == 3 is supported");
    end

    // Stage 1 combinational: unpack and classify.
    logic [7:0]        exp_a, exp_b;
    logic              zero_a, zero_b, spec_a, spec_b;
    logic [23:0]       man_a_d, man_b_d;
    logic signed [9:0] exp_sum_d;

    always_comb begin
        exp_a     = a[30:23];
        exp_b     = b[30:23];
        zero_a    = (exp_a == 8'h00);
        zero_b    = (exp_b == 8'h00);
        spec_a    = (exp_a == 8'hFF);
        spec_b    = (exp_b == 8'hFF);
        man_a_d   = zero_a ? 24'h0 : {1'b1, a[22:0]};
        man_b_d   = zero_b ? 24'h0 : {1'b1, b[22:0]};
        exp_sum_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
    end

    logic              v1_q;
    logic              s1_sign_q;
    logic signed [9:0] s1_exp_q;
    logic [23:0]       s1_man_a_q, s1_man_b_q;
    logic              s1_zero_q, s1_inf_q, s1_nan_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_a_q <= '0;
            s1_man_b_q <= '0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
        end else if (!stall) begin
            v1_q       <= valid_in;
            s1_sign_q  <= a[31] ^ b[31];
            s1_exp_q   <= exp_sum_d;
            s1_man_a_q <= man_a_d;
            s1_man_b_q <= man_b_d;
            s1_zero_q  <= zero_a | zero_b;
            s1_inf_q   <= spec_a | spec_b;
            s1_nan_q   <= (spec_a & zero_b) | (zero_a & spec_b);
        end
    end

    // Stage 2: full 24x24 mantissa product.
    logic [47:0]       prod_d;
    logic              v2_q;
    logic              s2_sign_q;
    logic signed [9:0] s2_exp_q;
    logic [47:0]       s2_prod_q;
    logic              s2_zero_q, s2_inf_q, s2_nan_q;

    always_comb begin
        prod_d = 48'(s1_man_a_q) * 48'(s1_man_b_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_prod_q <= '0;
            s2_zero_q <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_nan_q  <= 1'b0;
        end else if (!stall) begin
            v2_q      <= v1_q;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= prod_d;
            s2_zero_q <= s1_zero_q;
            s2_inf_q  <= s1_inf_q;
            s2_nan_q  <= s1_nan_q;
        end
    end

    // Stage 3: normalize by at most one bit, then pack with specials taking priority.
    logic signed [9:0] exp_norm;
    logic [22:0]       frac_norm;
    logic [31:0]       y_d;

    always_comb begin
        if (s2_prod_q[47]) begin
            frac_norm = s2_prod_q[46:24];
            exp_norm  = s2_exp_q + 10'sd1;
        end else begin
            frac_norm = s2_prod_q[45:23];
            exp_norm  = s2_exp_q;
        end

        if (s2_nan_q) begin
            y_d = 32'h7FC0_0000;
        end else if (s2_inf_q) begin
            y_d = {s2_sign_q, 8'hFF, 23'h0};
        end else if (s2_zero_q) begin
            y_d = {s2_sign_q, 31'h0};
        end else if (exp_norm >= 10'sd255) begin
            y_d = {s2_sign_q, 8'hFF, 23'h0};
        end else if (exp_norm <= 10'sd0) begin
            y_d = {s2_sign_q, 31'h0};
        end else begin
            y_d = {s2_sign_q, exp_norm[7:0], frac_norm};
        end
    end

    logic        valid_out_q;
    logic [31:0] y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_q <= 1'b0;
            y_q         <= 32'h0;
        end else if (!stall) begin
            valid_out_q <= v2_q;
            y_q         <= y_d;
        end
    end

    assign valid_out = valid_out_q;
    assign y         = y_q;

endmodule
